// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes and FSM states.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_e;

  // Widths whose natural alignment is violated by the low address bits.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] byte_off);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_H, F3_HU: mis = byte_off[0];
      F3_W:        mis = (byte_off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic is_legal_f3(input logic is_store, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lane_shifter.sv
// Combinational byte/half lane steering: extracts and extends loads, and merges
// sub-word store data into the word read back from memory.
module lane_shifter
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  funct3_i,
  input  logic [15:0] store_data_i,
  output logic [31:0] load_val_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (byte_off_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    load_val_o = word_i;
    case (funct3_i)
      F3_B:    load_val_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_val_o = {24'h000000, byte_sel};
      F3_H:    load_val_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_val_o = {16'h0000, half_sel};
      default: load_val_o = word_i;
    endcase
  end

  // Only the addressed lane is replaced; the rest of the word is preserved.
  always_comb begin
    merged_o = word_i;
    case (funct3_i)
      F3_B: begin
        case (byte_off_i)
          2'd0: merged_o[7:0]   = store_data_i[7:0];
          2'd1: merged_o[15:8]  = store_data_i[7:0];
          2'd2: merged_o[23:16] = store_data_i[7:0];
          2'd3: merged_o[31:24] = store_data_i[7:0];
          default: merged_o = word_i;
        endcase
      end
      F3_H: begin
        if (byte_off_i[1]) begin
          merged_o[31:16] = store_data_i;
        end else begin
          merged_o[15:0] = store_data_i;
        end
      end
      default: merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-only data memory. Sub-word stores are done
// as a read-modify-write that stalls the pipeline for the read cycle.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        access_fault,
  output logic        fault_sticky,
  output logic [31:0] mem_A,
  output logic        mem_WE,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  state_e      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic        fault_sticky_q, fault_sticky_d;

  logic        bad_req;
  logic        do_load;
  logic        do_sw;
  logic        do_rmw;
  logic [31:0] load_val;
  logic [31:0] merged_word;

  lane_shifter u_lane_shifter (
    .word_i       (mem_RD),
    .byte_off_i   (addr[1:0]),
    .funct3_i     (funct3),
    .store_data_i (wdata[15:0]),
    .load_val_o   (load_val),
    .merged_o     (merged_word)
  );

  // Requests are only decoded in IDLE; in RMW_WR the held instruction is already known good.
  always_comb begin
    bad_req      = !is_legal_f3(req_write, funct3) || is_misaligned(funct3, addr[1:0]);
    access_fault = (state_q == IDLE) && req_valid && bad_req;
    do_load      = (state_q == IDLE) && req_valid && !req_write && !bad_req;
    do_sw        = (state_q == IDLE) && req_valid && req_write && !bad_req && (funct3 == F3_W);
    do_rmw       = (state_q == IDLE) && req_valid && req_write && !bad_req && (funct3 != F3_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      merge_q        <= 32'h0000_0000;
      fault_sticky_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      merge_q        <= merge_d;
      fault_sticky_q <= fault_sticky_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    merge_d        = merge_q;
    fault_sticky_d = fault_sticky_q | access_fault;
    case (state_q)
      IDLE: begin
        if (do_rmw) begin
          state_d = RMW_WR;
          merge_d = merged_word;
        end
      end
      RMW_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write enable is masked by rst so a reset landing on the write cycle leaves memory intact.
  always_comb begin
    stall  = 1'b0;
    mem_WE = 1'b0;
    mem_WD = 32'h0000_0000;
    rdata  = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        if (do_load) begin
          rdata = load_val;
        end
        if (do_sw) begin
          mem_WE = !rst;
          mem_WD = wdata;
        end
        if (do_rmw) begin
          stall = 1'b1;
        end
      end
      RMW_WR: begin
        mem_WE = !rst;
        mem_WD = merge_q;
      end
      default: begin
        stall  = 1'b0;
        mem_WE = 1'b0;
      end
    endcase
  end

  assign mem_A        = {addr[31:2], 2'b00};
  assign fault_sticky = fault_sticky_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 16-word data memory, a vector table, directed
// multi-cycle sequences and a randomized run against an arithmetic reference.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        access_fault;
  logic        fault_sticky;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic        bd_we;
  logic [3:0]  bd_idx;
  logic [31:0] bd_data;

  int assert_count = 0;
  int fail_count   = 0;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .stall        (stall),
    .rdata        (rdata),
    .access_fault (access_fault),
    .fault_sticky (fault_sticky),
    .mem_A        (mem_a),
    .mem_WE       (mem_we),
    .mem_WD       (mem_wd),
    .mem_RD       (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory writes at the clock edge; a backdoor port lets the bench preload words.
  assign mem_rd = mem[mem_a[5:2]];
  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_we) mem[mem_a[5:2]] <= mem_wd;
  end

  typedef struct {
    logic        valid;
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    logic        exp_stall;
    logic        exp_we;
    logic        exp_sticky;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic w, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_write = w;
    funct3    = f;
    addr      = a;
    wdata     = d;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    bd_we   = 1'b1;
    bd_idx  = 4'(idx);
    bd_data = data;
    tick();
    bd_we   = 1'b0;
  endtask

  // Reference rules written from the ISA semantics: access size, natural alignment, lane math.
  function automatic int ref_size(input logic [2:0] f);
    case (f[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic ref_legal(input logic w, input logic [2:0] f, input logic [31:0] a);
    int sz;
    sz = ref_size(f);
    if (sz == 0) return 1'b0;
    if (w && f[2]) return 1'b0;
    if (!w && f[2] && sz == 4) return 1'b0;
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f, input logic [31:0] a);
    int          sz;
    logic [31:0] v;
    sz = ref_size(f);
    v  = word >> (8 * (a % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!f[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] word, input logic [2:0] f,
                                            input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask;
    mask = ((ref_size(f) == 1) ? 32'hFF : 32'hFFFF) << (8 * (a % 4));
    return (word & ~mask) | ((d << (8 * (a % 4))) & mask);
  endfunction

  initial begin
    int          stall_pulses;
    logic        v, w, legal, exp_fault, is_rmw, is_sw;
    logic [2:0]  f;
    logic [31:0] a, d, word;
    logic [2:0]  legal_f3 [5];
    logic        ref_sticky;

    legal_f3[0] = F3_B; legal_f3[1] = F3_H; legal_f3[2] = F3_W;
    legal_f3[3] = F3_BU; legal_f3[4] = F3_HU;

    vecs[0]  = '{1'b1, 1'b0, F3_W,   32'h8, 32'h0,         32'h80F17F02, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, F3_B,   32'hB, 32'h0,         32'hFFFFFF80, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, F3_BU,  32'hB, 32'h0,         32'h00000080, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, F3_B,   32'h9, 32'h0,         32'h0000007F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, F3_H,   32'hA, 32'h0,         32'hFFFF80F1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, F3_HU,  32'h8, 32'h0,         32'h00007F02, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, F3_H,   32'h9, 32'h0,         32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, F3_W,   32'hA, 32'h0,         32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 3'b110, 32'h8, 32'h0,         32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h8, 32'h0,         32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, F3_W,   32'h2, 32'h12345678,  32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 3'b100, 32'h8, 32'h12345678,  32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, F3_W,   32'hC, 32'hCAFEBABE,  32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 1'b0, F3_W,   32'hC, 32'h0,         32'hCAFEBABE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, F3_B,   32'h9, 32'h0,         32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};

    bd_we = 1'b0; bd_idx = 4'd0; bd_data = 32'h0;
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, F3_B, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 16; i++) preload(i, 32'h0);
    preload(1, 32'h11223344);
    preload(2, 32'h80F17F02);
    rst = 1'b0;
    #3;
    check_output("reset stall", 32'(stall), 32'h0);
    check_output("reset mem_WE", 32'(mem_we), 32'h0);
    check_output("reset access_fault", 32'(access_fault), 32'h0);
    check_output("reset fault_sticky", 32'(fault_sticky), 32'h0);
    tick();

    // Single-cycle table: loads, faults, SW and an idle cycle.
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i].valid, vecs[i].write, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      #3;
      check_output($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
      check_output($sformatf("vec%0d access_fault", i), 32'(access_fault), 32'(vecs[i].exp_fault));
      check_output($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].exp_stall));
      check_output($sformatf("vec%0d mem_WE", i), 32'(mem_we), 32'(vecs[i].exp_we));
      check_output($sformatf("vec%0d fault_sticky", i), 32'(fault_sticky), 32'(vecs[i].exp_sticky));
      check_output($sformatf("vec%0d mem_A", i), mem_a, {vecs[i].addr[31:2], 2'b00});
      tick();
    end
    check_output("faulted SW left word0", mem[0], 32'h0);
    check_output("SW wrote word3", mem[3], 32'hCAFEBABE);

    // SB at 0x5 followed by SH at 0x6 and half loads of the result.
    apply_stimulus(1'b1, 1'b1, F3_B, 32'h5, 32'h000000AA);
    #3;
    check_output("SB c0 stall", 32'(stall), 32'h1);
    check_output("SB c0 mem_WE", 32'(mem_we), 32'h0);
    tick(); #3;
    check_output("SB c1 stall", 32'(stall), 32'h0);
    check_output("SB c1 mem_WE", 32'(mem_we), 32'h1);
    tick();
    check_output("SB word1", mem[1], 32'h1122AA44);
    apply_stimulus(1'b0, 1'b0, F3_B, 32'h0, 32'h0);
    preload(1, 32'h11223344);
    apply_stimulus(1'b1, 1'b1, F3_H, 32'h6, 32'h0000BEEF);
    #3;
    check_output("SH c0 stall", 32'(stall), 32'h1);
    tick(); tick();
    check_output("SH word1", mem[1], 32'hBEEF3344);
    apply_stimulus(1'b1, 1'b0, F3_HU, 32'h6, 32'h0);
    #3;
    check_output("LHU after SH", rdata, 32'h0000BEEF);
    tick();
    apply_stimulus(1'b1, 1'b0, F3_H, 32'h6, 32'h0);
    #3;
    check_output("LH after SH", rdata, 32'hFFFFBEEF);
    check_output("sticky persists", 32'(fault_sticky), 32'h1);
    tick();

    // Reset arriving on the write cycle of an SB must suppress the write.
    apply_stimulus(1'b0, 1'b0, F3_B, 32'h0, 32'h0);
    preload(1, 32'h11223344);
    apply_stimulus(1'b1, 1'b1, F3_B, 32'h4, 32'h00000055);
    #3;
    check_output("rstRMW c0 stall", 32'(stall), 32'h1);
    tick();
    rst = 1'b1;
    #3;
    check_output("rstRMW c1 mem_WE", 32'(mem_we), 32'h0);
    tick();
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b0, F3_B, 32'h0, 32'h0);
    #3;
    check_output("rstRMW after stall", 32'(stall), 32'h0);
    check_output("rstRMW word1", mem[1], 32'h11223344);
    check_output("rstRMW sticky cleared", 32'(fault_sticky), 32'h0);
    tick();
    apply_stimulus(1'b1, 1'b0, F3_W, 32'h4, 32'h0);
    #3;
    check_output("rstRMW idle LW stall", 32'(stall), 32'h0);
    check_output("rstRMW idle LW rdata", rdata, 32'h11223344);
    tick();

    // Back-to-back SB on word 0: four cycles, two stall pulses.
    apply_stimulus(1'b0, 1'b0, F3_B, 32'h0, 32'h0);
    preload(0, 32'h0);
    stall_pulses = 0;
    apply_stimulus(1'b1, 1'b1, F3_B, 32'h0, 32'h00000011);
    #3; stall_pulses += int'(stall);
    tick(); #3; stall_pulses += int'(stall);
    check_output("b2b first mem_WD", mem_wd, 32'h00000011);
    tick();
    apply_stimulus(1'b1, 1'b1, F3_B, 32'h1, 32'h00000022);
    #3; stall_pulses += int'(stall);
    tick(); #3; stall_pulses += int'(stall);
    check_output("b2b second mem_WD", mem_wd, 32'h00002211);
    tick();
    apply_stimulus(1'b0, 1'b0, F3_B, 32'h0, 32'h0);
    check_output("b2b stall pulses", 32'(stall_pulses), 32'd2);
    check_output("b2b word0", mem[0], 32'h00002211);

    // Randomized run against the reference model.
    rst = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      preload(i, ref_mem[i]);
    end
    rst = 1'b0;
    tick();
    ref_sticky = 1'b0;
    for (int n = 0; n < 300; n++) begin
      v = ($urandom_range(0, 3) != 0);
      w = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 2) != 0 && ref_size(f) != 0) a = a - (a % ref_size(f));
      d = $urandom;
      legal     = ref_legal(w, f, a);
      exp_fault = v && !legal;
      is_sw     = v && legal && w && ref_size(f) == 4;
      is_rmw    = v && legal && w && ref_size(f) != 4;
      word      = ref_mem[a / 4];
      apply_stimulus(v, w, f, a, d);
      #3;
      check_output($sformatf("rnd%0d access_fault", n), 32'(access_fault), 32'(exp_fault));
      check_output($sformatf("rnd%0d fault_sticky", n), 32'(fault_sticky), 32'(ref_sticky));
      check_output($sformatf("rnd%0d stall", n), 32'(stall), 32'(is_rmw));
      check_output($sformatf("rnd%0d mem_WE", n), 32'(mem_we), 32'(is_sw));
      check_output($sformatf("rnd%0d rdata", n), rdata,
                   (v && legal && !w) ? ref_load(word, f, a) : 32'h0);
      if (is_sw) begin
        check_output($sformatf("rnd%0d SW mem_WD", n), mem_wd, d);
        ref_mem[a / 4] = d;
      end
      ref_sticky = ref_sticky | exp_fault;
      if (is_rmw) begin
        tick(); #3;
        check_output($sformatf("rnd%0d RMW mem_WE", n), 32'(mem_we), 32'h1);
        check_output($sformatf("rnd%0d RMW stall", n), 32'(stall), 32'h0);
        check_output($sformatf("rnd%0d RMW mem_WD", n), mem_wd, ref_merge(word, f, a, d));
        ref_mem[a / 4] = ref_merge(word, f, a, d);
      end
      tick();
    end
    apply_stimulus(1'b0, 1'b0, F3_B, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      check_output($sformatf("final word%0d", i), mem[i], ref_mem[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the MEM-stage pipeline register and the word-only data memory of the RISC-V pipeline. Converts byte/halfword/word loads and stores (LB, LH, LW, LBU, LHU, SB, SH, SW) into whole-word memory accesses. Sub-word stores become a two-cycle read-modify-write, with a pipeline stall asserted for the first cycle. Loads are extracted and sign- or zero-extended from the word the memory returns.

## Interface
- No parameters; data and address width are fixed at 32.
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  MEM stage holds a memory instruction this cycle.
- req_write  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V width/sign field.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data; the low byte/half is used for SB/SH.
- stall  out  1  hold IF/ID/EX/MEM registers this cycle.
- rdata  out  32  extended load result to MEM/WB.
- access_fault  out  1  current request is misaligned or has an illegal funct3.
- fault_sticky  out  1  set on any fault; cleared only by rst.
- mem_A  out  32  word address to data memory, always {addr[31:2], 2'b00}.
- mem_WE  out  1  data memory write enable.
- mem_WD  out  32  data memory write data.
- mem_RD  in  32  data memory read data (combinational from mem_A).

## Operation
- Two states: IDLE and RMW_WR.
- Legal loads (funct3 = 000, 001, 010, 100, 101) complete combinationally in the request cycle:
  - stall = 0, mem_WE = 0.
  - Byte lane selected by addr[1:0]; half lane selected by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes mem_RD through.
- SW (funct3 010):
  - Single cycle, IDLE only: mem_WE = 1, mem_WD = wdata, stall = 0.
- SB/SH in IDLE:
  - stall = 1, mem_WE = 0.
  - Merge wdata into mem_RD at the addressed lane; register the result in merge_q.
  - Next state RMW_WR.
- RMW_WR:
  - mem_WE = 1, mem_WD = merge_q, stall = 0.
  - Request inputs are not re-decoded (the pipeline holds the same instruction).
  - Next state IDLE.
- Faults:
  - Misaligned: LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] ≠ 00.
  - Illegal funct3: loads with 011/110/111; stores with 011 or 1xx.
  - On a fault: access_fault = 1, mem_WE = 0, rdata = 0, stall = 0, state stays IDLE.
  - fault_sticky is set at the next edge.
- req_valid = 0: mem_WE = 0, stall = 0, access_fault = 0, rdata = 0.

## Timing
- Reset values: state IDLE, merge_q = 0, fault_sticky = 0.
  - Consequently stall = 0, mem_WE = 0, access_fault = 0.
- Load latency 0 cycles (combinational through mem_RD).
- SW: the write lands at the end of the request cycle.
- SB/SH: 2 cycles.
  - Cycle 0: read, stall = 1.
  - Cycle 1: write lands at the end of cycle 1.
  - The pipeline advances after cycle 1.
- A load in the cycle after any store reads the updated word (memory writes at the edge).
- rst during RMW_WR: state → IDLE and no write is issued. The memory word is unchanged.
- rst has priority over every other transition.
- Back-to-back SB: each takes 2 cycles. The second SB's read (its cycle 0) sees the first SB's write.

## Structure
- Shared package mem_pkg:
  - funct3 constants: F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101.
  - State enum {IDLE, RMW_WR}.
- One combinational sub-module lane_shifter, used for both directions:
  - Load direction: extract and extend.
  - Store direction: merge.
  - Inputs: word, addr[1:0], funct3, store data.
  - Outputs: extended load value, merged store word.
- The top module holds the FSM, merge_q, fault logic and mem_* muxing.

## Test plan
- LW/LB/LBU at addr 0x8 with memory word 0x80F1_7F02:
  - LW → 0x80F17F02.
  - LB at 0xB → 0xFFFFFF80.
  - LBU at 0xB → 0x00000080.
  - stall = 0 throughout.
- SB at addr 0x5, wdata 0xAA, word 1 = 0x11223344:
  - stall = 1 for one cycle; mem_WE = 1 in the next cycle.
  - Word becomes 0x1122AA44.
- SH at addr 0x6, wdata 0xBEEF, word 1 = 0x11223344 → word 0xBEEF3344.
  - A following LHU at 0x6 → 0x0000BEEF.
  - A following LH at 0x6 → 0xFFFFBEEF.
- SW at addr 0x2 → access_fault = 1, mem_WE = 0, memory unchanged, fault_sticky = 1 from the next cycle.
  - Load with funct3 = 110 → also faults.
- rst asserted during RMW_WR of SB at 0x4 → no write; word unchanged; stall = 0, state IDLE after the edge.
- Back-to-back SB at 0x0 (0x11) then 0x1 (0x22) on word 0x00000000:
  - Total 4 cycles, two stall pulses.
  - Final word 0x00002211.
